// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage of the pipelined RV32I core. Owns the fetch PC, presents it
// combinationally to instruction memory and captures the returned word into
// the IF/ID pipeline register for the decode stage. Supports fetch stall,
// decode stall, decode flush (bubble insertion) and execute-stage redirect.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   defined     -> fetch_cnt / bubble_cnt are live wrapping counters
//   not defined -> no counter registers, both outputs tied to zero
//
// Parameters
//   RESET_PC   PC value loaded on reset
//   NOP_INSTR  bubble encoding (addi x0,x0,0) loaded on reset/flush
//   CNT_W      width of the performance counters
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   stall_f        hold the fetch PC this cycle
//   stall_d        hold the IF/ID register this cycle
//   flush_d        load a bubble into the IF/ID register
//   pcsrc_e        redirect the PC to pctarget_e (overrides stall_f)
//   pctarget_e     redirect target from execute, used as-is
//   imem_addr      byte address to instruction memory (= pc_f)
//   imem_rd        instruction word returned in the same cycle
//   pc_f           current fetch PC
//   instr_d        IF/ID instruction
//   pc_d           IF/ID PC of instr_d
//   pcplus4_d      IF/ID pc_d + 4
//   valid_d        IF/ID 1 = real instruction, 0 = bubble
//   fetch_cnt      real instructions captured into IF/ID
//   bubble_cnt     flush bubbles inserted into IF/ID
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_f,
  input  logic             stall_d,
  input  logic             flush_d,
  input  logic             pcsrc_e,
  input  logic [31:0]      pctarget_e,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rd,
  output logic [31:0]      pc_f,
  output logic [31:0]      instr_d,
  output logic [31:0]      pc_d,
  output logic [31:0]      pcplus4_d,
  output logic             valid_d,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [31:0] pcF_q, pcF_d;
  logic [31:0] pcPlus4F;
  logic [31:0] instrD_q, instrD_d;
  logic [31:0] pcD_q, pcD_d;
  logic [31:0] pcPlus4D_q, pcPlus4D_d;
  logic        validD_q, validD_d;

  // Shared incrementer; wraps modulo 2^32 with no overflow indication.
  assign pcPlus4F = pcF_q + 32'd4;

  // Redirect wins over stall_f so a taken branch is never lost to a stall.
  always_comb begin
    pcF_d = pcF_q;
    if (pcsrc_e) begin
      pcF_d = pctarget_e;
    end else if (!stall_f) begin
      pcF_d = pcPlus4F;
    end
  end

  // Flush wins over stall_d; a flush keeps pc_d/pcplus4_d so only the
  // instruction and valid bit change.
  always_comb begin
    instrD_d   = instrD_q;
    pcD_d      = pcD_q;
    pcPlus4D_d = pcPlus4D_q;
    validD_d   = validD_q;
    if (flush_d) begin
      instrD_d = NOP_INSTR;
      validD_d = 1'b0;
    end else if (!stall_d) begin
      instrD_d   = imem_rd;
      pcD_d      = pcF_q;
      pcPlus4D_d = pcPlus4F;
      validD_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcF_q      <= RESET_PC;
      instrD_q   <= NOP_INSTR;
      pcD_q      <= 32'd0;
      pcPlus4D_q <= 32'd0;
      validD_q   <= 1'b0;
    end else begin
      pcF_q      <= pcF_d;
      instrD_q   <= instrD_d;
      pcD_q      <= pcD_d;
      pcPlus4D_q <= pcPlus4D_d;
      validD_q   <= validD_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] fetchCnt_q, fetchCnt_d;
  logic [CNT_W-1:0] bubbleCnt_q, bubbleCnt_d;

  // Counters follow exactly the IF/ID capture decision above.
  always_comb begin
    fetchCnt_d  = fetchCnt_q;
    bubbleCnt_d = bubbleCnt_q;
    if (flush_d) begin
      bubbleCnt_d = bubbleCnt_q + CNT_W'(1);
    end else if (!stall_d) begin
      fetchCnt_d = fetchCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetchCnt_q  <= '0;
      bubbleCnt_q <= '0;
    end else begin
      fetchCnt_q  <= fetchCnt_d;
      bubbleCnt_q <= bubbleCnt_d;
    end
  end

  assign fetch_cnt  = fetchCnt_q;
  assign bubble_cnt = bubbleCnt_q;
`else
  assign fetch_cnt  = '0;
  assign bubble_cnt = '0;
`endif

  assign imem_addr = pcF_q;
  assign pc_f      = pcF_q;
  assign instr_d   = instrD_q;
  assign pc_d      = pcD_q;
  assign pcplus4_d = pcPlus4D_q;
  assign valid_d   = validD_q;

endmodule
